pe_array_ctrl: RTL and testbench

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/pe_array_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
// Controller for a systolic PE chain: loads per-PE weights, streams samples into the
// chain and tracks in-flight samples so the pass ends only after the last result exits.
module pe_array_ctrl #(
  parameter int unsigned NUM_PE    = 9,
  parameter int unsigned ADDR_BW   = 5,
  parameter int unsigned WEIGHT_BW = 8,
  parameter int unsigned DATA_BW   = 8,
  parameter int unsigned PIPE_LAT  = NUM_PE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 s_w_valid,
  output logic                 s_w_ready,
  input  logic [WEIGHT_BW-1:0] s_w_data,
  input  logic                 i_start,
  input  logic [15:0]          i_len,
  input  logic                 s_x_valid,
  output logic                 s_x_ready,
  input  logic [DATA_BW-1:0]   s_x_data,
  output logic                 o_w_en,
  output logic [ADDR_BW-1:0]   o_addr,
  output logic [WEIGHT_BW-1:0] o_w,
  output logic [DATA_BW-1:0]   o_x,
  output logic                 o_x_en,
  output logic                 o_res_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_w_loaded
);

  localparam int unsigned CNT_BW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_BW-1:0]     cnt_q, cnt_d;
  logic [CNT_BW-1:0]     len_q, len_d;
  logic                  w_loaded_q, w_loaded_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_BW-1:0]    addr_q, addr_d;
  logic [WEIGHT_BW-1:0]  w_q, w_d;
  logic [DATA_BW-1:0]    x_q, x_d;
  logic                  x_en_q, x_en_d;
  logic [PIPE_LAT-1:0]   sr_q, sr_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  w_rdy_q, w_rdy_d;
  logic                  x_rdy_q, x_rdy_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    w_loaded_d = w_loaded_q;
    w_en_d     = 1'b0;
    addr_d     = addr_q;
    w_d        = w_q;
    x_en_d     = 1'b0;
    x_d        = x_q;
    err_d      = 1'b0;
    sr_d       = PIPE_LAT'({sr_q, x_en_q});

    case (state_q)
      IDLE: begin
        if (i_load) begin
          state_d    = LOAD;
          cnt_d      = '0;
          w_loaded_d = 1'b0;
        end else if (i_start) begin
          if (!w_loaded_q) begin
            err_d = 1'b1;
          end else if (i_len == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            len_d   = i_len;
            cnt_d   = '0;
          end
        end
      end
      LOAD: begin
        if (s_w_valid) begin
          w_en_d = 1'b1;
          w_d    = s_w_data;
          addr_d = ADDR_BW'(cnt_q);
          if (cnt_q == CNT_BW'(NUM_PE - 1)) begin
            state_d    = IDLE;
            w_loaded_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      RUN: begin
        if (s_x_valid) begin
          x_en_d = 1'b1;
          x_d    = s_x_data;
          if (cnt_q == len_q - 16'd1) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        // The last sample's qualifier has not entered the shift register yet on the first DRAIN cycle
        if (sr_q == '0 && !x_en_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    w_rdy_d = (state_d == LOAD);
    x_rdy_d = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      w_loaded_q <= 1'b0;
      w_en_q     <= 1'b0;
      addr_q     <= '0;
      w_q        <= '0;
      x_q        <= '0;
      x_en_q     <= 1'b0;
      sr_q       <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      w_rdy_q    <= 1'b0;
      x_rdy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      w_loaded_q <= w_loaded_d;
      w_en_q     <= w_en_d;
      addr_q     <= addr_d;
      w_q        <= w_d;
      x_q        <= x_d;
      x_en_q     <= x_en_d;
      sr_q       <= sr_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      w_rdy_q    <= w_rdy_d;
      x_rdy_q    <= x_rdy_d;
    end
  end

  assign s_w_ready   = w_rdy_q;
  assign s_x_ready   = x_rdy_q;
  assign o_w_en      = w_en_q;
  assign o_addr      = addr_q;
  assign o_w         = w_q;
  assign o_x         = x_q;
  assign o_x_en      = x_en_q;
  assign o_res_valid = sr_q[PIPE_LAT-1];
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_w_loaded  = w_loaded_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized self-checking bench for pe_array_ctrl; expectations come from a
// transaction-level model (accepted-sample times plus fixed chain latency).
module tb_pe_array_ctrl;

  localparam int NUM_PE   = 9;
  localparam int ADDR_BW  = 5;
  localparam int WB       = 8;
  localparam int DB       = 8;
  localparam int PIPE_LAT = NUM_PE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_load = 1'b0;
  logic          s_w_valid = 1'b0;
  logic          s_w_ready;
  logic [WB-1:0] s_w_data = '0;
  logic          i_start = 1'b0;
  logic [15:0]   i_len = '0;
  logic          s_x_valid = 1'b0;
  logic          s_x_ready;
  logic [DB-1:0] s_x_data = '0;
  logic          o_w_en;
  logic [ADDR_BW-1:0] o_addr;
  logic [WB-1:0] o_w;
  logic [DB-1:0] o_x;
  logic          o_x_en;
  logic          o_res_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic          o_w_loaded;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  pe_array_ctrl #(
    .NUM_PE(NUM_PE), .ADDR_BW(ADDR_BW), .WEIGHT_BW(WB), .DATA_BW(DB), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_load(i_load),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .i_start(i_start), .i_len(i_len),
    .s_x_valid(s_x_valid), .s_x_ready(s_x_ready), .s_x_data(s_x_data),
    .o_w_en(o_w_en), .o_addr(o_addr), .o_w(o_w),
    .o_x(o_x), .o_x_en(o_x_en), .o_res_valid(o_res_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_w_loaded(o_w_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] all_out;
    repeat (3) step();
    all_out = {s_w_ready, s_x_ready, o_w_en, 27'(o_addr), o_w, o_x, o_x_en, o_res_valid,
               o_busy, o_done, o_err, o_w_loaded};
    checks++;
    if (all_out !== 64'd0) $display("FAIL reset_outputs got=%h want=0", all_out);
    else passed++;
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (o_busy !== 1'b0 || o_w_loaded !== 1'b0) $display("FAIL reset_release busy=%b loaded=%b want 0/0", o_busy, o_w_loaded);
    else passed++;
  endtask

  task automatic test_err_unloaded();
    i_start = 1'b1; i_len = 16'd5; s_x_valid = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) $display("FAIL err_pulse err=%b busy=%b want 1/0", o_err, o_busy);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (o_err !== 1'b0 || o_x_en !== 1'b0 || o_busy !== 1'b0 || s_x_ready !== 1'b0)
        $display("FAIL err_after cyc%0d err=%b x_en=%b busy=%b xrdy=%b want 0", i, o_err, o_x_en, o_busy, s_x_ready);
      else passed++;
    end
    s_x_valid = 1'b0;
  endtask

  // Loads NUM_PE weights; random_mode picks random data and gaps, otherwise 1..9 with one gap.
  task automatic load_pass(input bit random_mode, input bit with_start);
    logic [WB-1:0] w[NUM_PE];
    int idx = 0;
    bit v;
    for (int i = 0; i < NUM_PE; i++) w[i] = random_mode ? WB'($urandom) : WB'(i + 1);
    i_load = 1'b1;
    if (with_start) begin i_start = 1'b1; i_len = 16'd3; end
    step();
    i_load = 1'b0; i_start = 1'b0;
    checks++;
    if (s_w_ready !== 1'b1 || o_w_loaded !== 1'b0 || o_busy !== 1'b1 || o_err !== 1'b0 || s_x_ready !== 1'b0)
      $display("FAIL load_entry wrdy=%b loaded=%b busy=%b err=%b xrdy=%b want 1/0/1/0/0",
               s_w_ready, o_w_loaded, o_busy, o_err, s_x_ready);
    else passed++;
    for (int c = 0; c < 200 && idx < NUM_PE; c++) begin
      v = random_mode ? 1'($urandom_range(1)) : (c != 4);
      s_w_valid = v;
      s_w_data = w[idx];
      step();
      checks++;
      if (o_w_en !== v) $display("FAIL load_w_en beat%0d got=%b want=%b", idx, o_w_en, v);
      else passed++;
      if (v) begin
        checks++;
        if (o_addr !== ADDR_BW'(idx) || o_w !== w[idx])
          $display("FAIL load_beat addr=%0d w=%0d want addr=%0d w=%0d", o_addr, o_w, idx, w[idx]);
        else passed++;
        idx++;
      end
    end
    s_w_valid = 1'b0;
    checks++;
    if (idx != NUM_PE || o_w_loaded !== 1'b1 || s_w_ready !== 1'b0)
      $display("FAIL load_end beats=%0d loaded=%b wrdy=%b want %0d/1/0", idx, o_w_loaded, s_w_ready, NUM_PE);
    else passed++;
    step();
    checks++;
    if (o_w_en !== 1'b0 || o_busy !== 1'b0) $display("FAIL load_idle w_en=%b busy=%b want 0/0", o_w_en, o_busy);
    else passed++;
  endtask

  task automatic test_load();
    load_pass(1'b0, 1'b0);
  endtask

  task automatic test_load_start_same_cycle();
    load_pass(1'b1, 1'b1);
  endtask

  // One compute pass; each accepted sample must reappear as o_res_valid PIPE_LAT cycles later.
  task automatic run_pass(input int len, input int pct, input bit inject);
    int q[$];
    int acc = 0, res = 0, dn = 0, since = 0, budget;
    bit v, mrdy, exp_en, exp_res, done_seen = 0, injected = 0;
    logic [DB-1:0] d;
    budget = len * 4 + PIPE_LAT + 40;
    i_start = 1'b1; i_len = 16'(len);
    step();
    i_start = 1'b0; i_len = 16'($urandom);
    checks++;
    if (o_busy !== 1'b1 || s_x_ready !== 1'b1 || s_w_ready !== 1'b0 || o_err !== 1'b0)
      $display("FAIL run_entry busy=%b xrdy=%b wrdy=%b err=%b want 1/1/0/0", o_busy, s_x_ready, s_w_ready, o_err);
    else passed++;
    for (int c = 0; c < budget && !(done_seen && since >= 2); c++) begin
      mrdy = (acc < len);
      checks++;
      if (s_x_ready !== mrdy) $display("FAIL run_ready got=%b want=%b acc=%0d", s_x_ready, mrdy, acc);
      else passed++;
      v = ($urandom_range(99) < 32'(pct));
      d = DB'($urandom);
      s_x_valid = v; s_x_data = d;
      if (inject && !injected && acc == len / 2) begin
        i_start = 1'b1; i_load = 1'b1; i_len = 16'd2; injected = 1'b1;
      end
      step();
      i_start = 1'b0; i_load = 1'b0;
      exp_en = mrdy && v;
      checks++;
      if (o_x_en !== exp_en) $display("FAIL run_x_en got=%b want=%b acc=%0d", o_x_en, exp_en, acc);
      else passed++;
      if (exp_en) begin
        checks++;
        if (o_x !== d) $display("FAIL run_x_data got=%h want=%h", o_x, d);
        else passed++;
        acc++;
        q.push_back(cyc);
      end
      exp_res = (q.size() > 0) && (cyc == q[0] + PIPE_LAT);
      checks++;
      if (o_res_valid !== exp_res) $display("FAIL run_res_valid got=%b want=%b cyc=%0d", o_res_valid, exp_res, cyc);
      else passed++;
      if (exp_res) begin void'(q.pop_front()); res++; end
      if (inject) begin
        checks++;
        if (s_w_ready !== 1'b0 || o_err !== 1'b0) $display("FAIL run_inject wrdy=%b err=%b want 0/0", s_w_ready, o_err);
        else passed++;
      end
      if (o_done) begin
        dn++;
        done_seen = 1'b1;
        checks++;
        if (res != len) $display("FAIL run_done_early results=%0d want=%0d", res, len);
        else passed++;
      end
      if (done_seen) since++;
    end
    s_x_valid = 1'b0;
    checks++;
    if (!done_seen) $display("FAIL run_timeout done=0 want=1 len=%0d", len);
    else passed++;
    checks++;
    if (acc != len || res != len || dn != 1 || o_busy !== 1'b0)
      $display("FAIL run_totals x_en=%0d res=%0d done=%0d busy=%b want %0d/%0d/1/0", acc, res, dn, o_busy, len, len);
    else passed++;
  endtask

  task automatic test_run_basic();
    run_pass(4, 100, 1'b0);
  endtask

  task automatic test_run_random();
    for (int i = 0; i < 6; i++) run_pass(int'($urandom_range(20, 1)), 60, 1'b0);
    run_pass(1, 100, 1'b0);
  endtask

  task automatic test_start_during_run();
    run_pass(8, 70, 1'b1);
  endtask

  task automatic test_len_zero();
    i_start = 1'b1; i_len = 16'd0; s_x_valid = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_x_en !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL len0_done done=%b x_en=%b busy=%b want 1/0/1", o_done, o_x_en, o_busy);
    else passed++;
    for (int i = 0; i < PIPE_LAT + 3; i++) begin
      step();
      checks++;
      if (o_done !== 1'b0 || o_x_en !== 1'b0 || o_res_valid !== 1'b0 || o_busy !== 1'b0)
        $display("FAIL len0_after done=%b x_en=%b res=%b busy=%b want 0", o_done, o_x_en, o_res_valid, o_busy);
      else passed++;
    end
    s_x_valid = 1'b0;
  endtask

  task automatic test_len_max();
    run_pass(65535, 100, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] all_out;
    i_start = 1'b1; i_len = 16'd10; s_x_valid = 1'b1;
    step();
    i_start = 1'b0;
    repeat (5) step();
    checks++;
    if (o_busy !== 1'b1 || o_x_en !== 1'b1) $display("FAIL rst_mid_pre busy=%b x_en=%b want 1/1", o_busy, o_x_en);
    else passed++;
    rst_n = 1'b0;
    #1;
    all_out = {s_w_ready, s_x_ready, o_w_en, 27'(o_addr), o_w, o_x, o_x_en, o_res_valid,
               o_busy, o_done, o_err, o_w_loaded};
    checks++;
    if (all_out !== 64'd0) $display("FAIL rst_mid_async got=%h want=0", all_out);
    else passed++;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < PIPE_LAT + 10; i++) begin
      step();
      checks++;
      if (o_done !== 1'b0 || o_res_valid !== 1'b0 || o_w_loaded !== 1'b0 || o_busy !== 1'b0)
        $display("FAIL rst_mid_after done=%b res=%b loaded=%b busy=%b want 0", o_done, o_res_valid, o_w_loaded, o_busy);
      else passed++;
    end
    s_x_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_err_unloaded();
    test_load();
    test_run_basic();
    test_len_zero();
    test_load_start_same_cycle();
    test_run_random();
    test_start_during_run();
    load_pass(1'b1, 1'b0);
    test_run_random();
    test_len_max();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
